keypad_scanner: RTL and testbench

//  Scans a 4x4 matrix keypad, the input-side counterpart of the multiplexed 7-seg driver.

---
 rtl/heroe_pkg.sv | 32 +++
 rtl/sync2.sv | 25 ++
 rtl/keypad_scanner.sv | 143 ++++++++++++++
 tb/tb_keypad_scanner.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/heroe_pkg.sv
// Shared types and constants for the board-input blocks and the game FSM.
package heroe_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } scan_state_t;

   // Key codes are {row[1:0], col[1:0]}.
   localparam logic [3:0] KEY_UP    = 4'b0001;
   localparam logic [3:0] KEY_DOWN  = 4'b1001;
   localparam logic [3:0] KEY_SEL   = 4'b0101;
   localparam logic [3:0] KEY_PAUSE = 4'b0011;

   // Index of the lowest active-low row; the lowest index wins on multiple hits.
   function automatic logic [1:0] low_row_idx(input logic [3:0] rows);
      logic [1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (!rows[3 - i]) idx = 2'(3 - i);
      end
      return idx;
   endfunction

   // Active-low one-cold column drive for a column index.
   function automatic logic [3:0] col_drive(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser with asynchronous active-high reset.
module sync2 #(
   parameter int                WIDTH   = 1,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // Two-stage capture of an asynchronous input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchronisation, debounce and
// one-pulse-per-press reporting.
module keypad_scanner
   import heroe_pkg::*;
#(
   parameter int SCAN_DIV       = 1350,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_in,
   output logic [3:0] col_sel,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [3:0]       row_s;
   logic [DIV_W-1:0] div;
   logic             tick;
   logic             hit;
   logic [3:0]       code;

   scan_state_t      state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [3:0]       cand, cand_nx;
   logic [1:0]       col_idx, col_idx_nx;
   logic [3:0]       key_code_nx;
   logic             key_valid_nx;
   logic             key_held_nx;

   sync2 #(
      .WIDTH   (4),
      .RST_VAL (4'hF)
   ) u_row_sync (
      .clk (clk),
      .rst (rst),
      .d   (row_in),
      .q   (row_s)
   );

   // Column-slot divider; tick marks the last clock of each slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)               div <= '0;
      else if (div == DIV_LAST) div <= '0;
      else                   div <= div + 1'b1;
   end

   assign tick    = (div == DIV_LAST);
   assign hit     = ~&row_s;
   assign code    = {low_row_idx(row_s), col_idx};
   assign col_sel = col_drive(col_idx);

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SCAN;
         cnt       <= '0;
         cand      <= '0;
         col_idx   <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         cand      <= cand_nx;
         col_idx   <= col_idx_nx;
         key_code  <= key_code_nx;
         key_valid <= key_valid_nx;
         key_held  <= key_held_nx;
      end
   end

   // Next-state logic: acts only on scan ticks; column frozen outside SCAN.
   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      cand_nx      = cand;
      col_idx_nx   = col_idx;
      key_code_nx  = key_code;
      key_valid_nx = 1'b0;
      key_held_nx  = key_held;
      if (tick) begin
         unique case (state)
            SCAN: begin
               if (hit) begin
                  state_nx = DEBOUNCE;
                  cnt_nx   = CNT_ONE;
                  cand_nx  = code;
               end else begin
                  col_idx_nx = col_idx + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (hit && (code == cand)) begin
                  if (cnt >= CNT_MAX) begin
                     key_code_nx  = cand;
                     key_valid_nx = 1'b1;
                     key_held_nx  = 1'b1;
                     state_nx     = PRESSED;
                     cnt_nx       = '0;
                  end else begin
                     cnt_nx = cnt + 1'b1;
                  end
               end else begin
                  state_nx   = SCAN;
                  col_idx_nx = col_idx + 2'd1;
               end
            end
            PRESSED: begin
               if (!hit) begin
                  state_nx = RELEASE;
                  cnt_nx   = CNT_ONE;
               end
            end
            RELEASE: begin
               if (!hit) begin
                  if (cnt >= CNT_MAX) begin
                     key_held_nx = 1'b0;
                     state_nx    = SCAN;
                     col_idx_nx  = col_idx + 2'd1;
                     cnt_nx      = '0;
                  end else begin
                     cnt_nx = cnt + 1'b1;
                  end
               end else begin
                  state_nx = PRESSED;
                  cnt_nx   = '0;
               end
            end
            default: state_nx = SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with SCAN_DIV=8, DEBOUNCE_SCANS=4.
module tb_keypad_scanner;
   import heroe_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] row_in;
   logic [3:0] col_sel;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [3:0] pressed [4];
   logic [3:0] exp_q [$];
   logic [2:0] tb_div;
   int         checks   = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   keypad_scanner #(
      .SCAN_DIV       (8),
      .DEBOUNCE_SCANS (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .row_in    (row_in),
      .col_sel   (col_sel),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   // Keypad matrix model: a pressed key pulls its row low while its column is driven.
   always_comb begin
      row_in = 4'hF;
      for (int unsigned c = 0; c < 4; c++) begin
         if (!col_sel[c]) row_in = row_in & ~pressed[c];
      end
   end

   // Reference slot counter used to locate scan ticks.
   always @(posedge clk or posedge rst) begin
      if (rst)              tb_div <= 3'd0;
      else if (tb_div == 7) tb_div <= 3'd0;
      else                  tb_div <= tb_div + 3'd1;
   end

   task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   // Advance to just after the next scan tick edge.
   task automatic next_tick();
      int n;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (tb_div != 3'd7 && n < 20);
      if (n >= 20) begin
         checks++;
         failures++;
         $display("FAIL tick_timeout actual=%0d required=<20", n);
      end
      #1;
   endtask

   // Monitor: every key_valid pulse must match the next queued expected code.
   always @(negedge clk) begin : monitor
      logic [3:0] e;
      if (!rst && key_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_key_valid actual=%b required=no_pulse", key_code);
         end else begin
            e = exp_q.pop_front();
            if (key_code !== e) begin
               failures++;
               $display("FAIL scoreboard_key_code actual=%b required=%b", key_code, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] idle_cols [4];
      idle_cols = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
      for (int unsigned c = 0; c < 4; c++) pressed[c] = 4'b0000;

      // Reset values
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check4("reset_col_sel", col_sel, 4'b1110);
      check4("reset_key_code", key_code, 4'b0000);
      check1("reset_key_valid", key_valid, 1'b0);
      check1("reset_key_held", key_held, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // 1. Idle rotation
      for (int unsigned i = 0; i < 4; i++) begin
         next_tick();
         check4("idle_col", col_sel, idle_cols[i]);
      end

      // 2. Row 2 in column 1, stable press
      pressed[1] = 4'b0100;
      exp_q.push_back(4'b1001);
      next_tick();
      check4("t2_col_advance", col_sel, 4'b1101);
      for (int unsigned i = 0; i < 4; i++) begin
         next_tick();
         check1("t2_held_before_accept", key_held, 1'b0);
         check4("t2_col_frozen", col_sel, 4'b1101);
      end
      next_tick();
      check1("t2_valid_latency", key_valid, 1'b1);
      check1("t2_held_on_accept", key_held, 1'b1);
      check4("t2_key_code", key_code, 4'b1001);
      for (int unsigned i = 0; i < 3; i++) begin
         next_tick();
         check1("t2_held", key_held, 1'b1);
         check1("t2_valid_low", key_valid, 1'b0);
         check4("t2_col_held", col_sel, 4'b1101);
      end

      // 5. Release, 2-tick release bounce, clean release
      pressed[1] = 4'b0000;
      next_tick();
      check1("t5_held_r1", key_held, 1'b1);
      next_tick();
      check1("t5_held_r2", key_held, 1'b1);
      pressed[1] = 4'b0100;
      next_tick();
      check1("t5_held_b1", key_held, 1'b1);
      next_tick();
      check1("t5_held_b2", key_held, 1'b1);
      check4("t5_col_b2", col_sel, 4'b1101);
      pressed[1] = 4'b0000;
      for (int unsigned i = 0; i < 4; i++) begin
         next_tick();
         check1("t5_held_clean", key_held, 1'b1);
         check4("t5_col_clean", col_sel, 4'b1101);
      end
      next_tick();
      check1("t5_held_drop", key_held, 1'b0);
      check4("t5_col_resume", col_sel, 4'b1011);

      // 3. Bounce in column 3, row 0 low for 2 ticks
      pressed[3] = 4'b0001;
      next_tick();
      check4("t3_col3", col_sel, 4'b0111);
      next_tick();
      check4("t3_frozen_d1", col_sel, 4'b0111);
      next_tick();
      check4("t3_frozen_d2", col_sel, 4'b0111);
      pressed[3] = 4'b0000;
      next_tick();
      check4("t3_reject_advance", col_sel, 4'b1110);
      check1("t3_no_held", key_held, 1'b0);
      next_tick();
      check4("t3_scan_resumed", col_sel, 4'b1101);

      // 4. Rows 1 and 3 together in column 2
      pressed[2] = 4'b1010;
      exp_q.push_back(4'b0110);
      next_tick();
      check4("t4_col2", col_sel, 4'b1011);
      for (int unsigned i = 0; i < 4; i++) begin
         next_tick();
         check1("t4_held_before", key_held, 1'b0);
      end
      next_tick();
      check1("t4_valid", key_valid, 1'b1);
      check4("t4_key_code", key_code, 4'b0110);
      next_tick();
      check1("t4_held", key_held, 1'b1);
      pressed[2] = 4'b0000;
      for (int unsigned i = 0; i < 4; i++) begin
         next_tick();
         check1("t4_held_release", key_held, 1'b1);
      end
      next_tick();
      check1("t4_held_drop", key_held, 1'b0);
      check4("t4_col_resume", col_sel, 4'b0111);

      // 6a. Reset during DEBOUNCE (row 0, column 1)
      pressed[1] = 4'b0001;
      next_tick();
      check4("t6_col0", col_sel, 4'b1110);
      next_tick();
      check4("t6_col1", col_sel, 4'b1101);
      next_tick();
      next_tick();
      check4("t6_debounce_frozen", col_sel, 4'b1101);
      #3;
      rst = 1'b1;
      #1;
      check4("t6_rst_debounce_col", col_sel, 4'b1110);
      check1("t6_rst_debounce_held", key_held, 1'b0);
      check1("t6_rst_debounce_valid", key_valid, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Key still down: scanning must find and accept it afresh
      exp_q.push_back(4'b0001);
      next_tick();
      check4("t6_resume_col1", col_sel, 4'b1101);
      for (int unsigned i = 0; i < 4; i++) begin
         next_tick();
         check1("t6_held_before", key_held, 1'b0);
      end
      next_tick();
      check1("t6_valid", key_valid, 1'b1);
      check4("t6_key_code", key_code, 4'b0001);
      check1("t6_held", key_held, 1'b1);

      // 6b. Reset during PRESSED
      next_tick();
      #2;
      rst = 1'b1;
      #1;
      check1("t6_rst_pressed_held", key_held, 1'b0);
      check4("t6_rst_pressed_col", col_sel, 4'b1110);
      check4("t6_rst_pressed_code", key_code, 4'b0000);
      check1("t6_rst_pressed_valid", key_valid, 1'b0);
      pressed[1] = 4'b0000;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         next_tick();
         check4("t6_after_col", col_sel, idle_cols[i]);
         check1("t6_after_held", key_held, 1'b0);
      end

      repeat (4) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drained actual=%0d required=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
